// File: rtl/mrisc_alu_pkg.sv
// Shared definitions for the MRISC32 packed ALU units: the pack mode
// encoding, lane counts, and the sequential multiplier's state and
// iteration count helpers.
package mrisc_alu_pkg;

    // Operand packing. The encoding is architectural, so each value is pinned.
    typedef enum logic [1:0] {
        PM_WORD = 2'b00,
        PM_HALF = 2'b01,
        PM_BYTE = 2'b10,
        PM_RSVD = 2'b11
    } pack_mode_t;

    // Number of independent lanes in a 32-bit operand for each mode.
    localparam int LANES_WORD = 1;
    localparam int LANES_HALF = 2;
    localparam int LANES_BYTE = 4;

    // The iteration counter must hold the largest lane width (32).
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } mul_state_t;

    // A radix-2 loop needs one iteration per bit of lane width.
    // Reserved mode never iterates.
    function automatic logic [CNT_W-1:0] iter_count(input pack_mode_t mode);
        case (mode)
            PM_WORD: return CNT_W'(32 / LANES_WORD);
            PM_HALF: return CNT_W'(32 / LANES_HALF);
            PM_BYTE: return CNT_W'(32 / LANES_BYTE);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/packed_add32.sv
// Combinational 32-bit adder built from four byte slices. The pack mode
// decides where the carry chain is cut, so each lane wraps on its own.
// Both the packed add/sub units and the sequential multiplier use it.
module packed_add32
    import mrisc_alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  pack_mode_t  pack_mode,
    output logic [31:0] sum
);

    // Bit k set: the carry into byte k is blocked because byte k starts a lane.
    logic [3:0] cut;
    logic [8:0] slice;
    logic       carry;

    // Select the lane boundaries for the current mode.
    always_comb begin
        case (pack_mode)
            PM_WORD: cut = 4'b0001;
            PM_HALF: cut = 4'b0101;
            default: cut = 4'b1111;
        endcase
    end

    // Ripple across the byte slices and drop the carry wherever a lane starts.
    // NOTE: every variable gets a value before any branch or loop. A path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        sum   = '0;
        carry = 1'b0;
        slice = '0;
        for (int k = 0; k < 4; k++) begin
            slice            = {1'b0, a[8*k +: 8]} + {1'b0, b[8*k +: 8]}
                             + {8'b0, carry & ~cut[k]};
            sum[8*k +: 8]    = slice[7:0];
            carry            = slice[8];
        end
    end

endmodule

// File: rtl/mul32_seq.sv
// Sequential packed multiplier. It produces the low half of each lane's
// product with a radix-2 shift-and-add loop. It runs 32, 16 or 8 iterations
// for word, half or byte lanes, and signals through a start/busy/done
// handshake.
module mul32_seq
    import mrisc_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  pack_mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    mul_state_t       state_q,  state_d;
    pack_mode_t       mode_q,   mode_d;
    logic [31:0]      mcand_q,  mcand_d;
    logic [31:0]      mplier_q, mplier_d;
    logic [31:0]      acc_q,    acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [31:0]      result_q, result_d;

    logic [31:0] lane_lsb_mask;
    logic [31:0] lane_msb_mask;
    logic [3:0]  byte_sel;
    logic [31:0] addend;
    logic [31:0] acc_sum;
    pack_mode_t  req_mode;

    assign req_mode = pack_mode_t'(pack_mode);

    // Build lane masks and per-byte add enables from the captured mode.
    always_comb begin
        case (mode_q)
            PM_WORD: begin
                lane_lsb_mask = 32'h0000_0001;
                lane_msb_mask = 32'h8000_0000;
                byte_sel      = {4{mplier_q[0]}};
            end
            PM_HALF: begin
                lane_lsb_mask = 32'h0001_0001;
                lane_msb_mask = 32'h8000_8000;
                byte_sel      = {{2{mplier_q[16]}}, {2{mplier_q[0]}}};
            end
            default: begin
                lane_lsb_mask = 32'h0101_0101;
                lane_msb_mask = 32'h8080_8080;
                byte_sel      = {mplier_q[24], mplier_q[16], mplier_q[8], mplier_q[0]};
            end
        endcase
    end

    // A lane adds its shifted multiplicand only when its multiplier LSB is set.
    assign addend = mcand_q & {{8{byte_sel[3]}}, {8{byte_sel[2]}},
                               {8{byte_sel[1]}}, {8{byte_sel[0]}}};

    packed_add32 u_add (
        .a         (acc_q),
        .b         (addend),
        .pack_mode (mode_q),
        .sum       (acc_sum)
    );

    // Next-state logic for the controller and the datapath registers.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (start) begin
                    mcand_d  = A;
                    mplier_d = B;
                    mode_d   = req_mode;
                    acc_d    = '0;
                    cnt_d    = iter_count(req_mode);
                    if (req_mode == PM_RSVD) begin
                        // Reserved mode completes immediately with a zero result.
                        result_d = '0;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = (mcand_q << 1) & ~lane_lsb_mask;
                mplier_d = (mplier_q >> 1) & ~lane_msb_mask;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = acc_sum;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any operation in flight.
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before this edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= PM_WORD;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Directed bench for mul32_seq. Expected products are computed by hand.
module tb_mul32_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  pack_mode;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    mul32_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (A),
        .B         (B),
        .pack_mode (pack_mode),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one operation and follow it to done.
    // b2b: issue start in the current (DONE) cycle instead of waiting one cycle.
    // inject_at: cycle after E0 at which a second start pulse is sent (-1 = none).
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] m, input logic [31:0] exp_res,
                          input int exp_lat, input bit b2b, input int inject_at);
        int          lat;
        int          busy_cnt;
        int          overlap;
        int          unstable;
        bit          seen;
        logic [31:0] prev;
        if (!b2b) begin
            @(negedge clk);
            check({tag, "_done_idle"}, 32'(done), 32'd0);
        end
        prev      = result;
        A         = a;
        B         = b;
        pack_mode = m;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        A         = 32'hA5A5_5A5A;
        B         = 32'h5A5A_A5A5;
        pack_mode = 2'b01;
        lat = 0; busy_cnt = 0; overlap = 0; unstable = 0; seen = 1'b0;
        while (!seen && lat <= 64) begin
            if (busy && done) overlap++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                if (result !== prev) unstable++;
                if (lat == inject_at) begin
                    start     = 1'b1;
                    A         = 32'hDEAD_BEEF;
                    B         = 32'h1234_5678;
                    pack_mode = 2'b10;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        check({tag, "_result_stable"}, 32'(unstable), 32'd0);
        check({tag, "_result"}, result, exp_res);
    endtask

    initial begin
        int done_cnt;
        rst_n     = 1'b0;
        start     = 1'b0;
        A         = '0;
        B         = '0;
        pack_mode = 2'b00;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;

        run_op("word",      32'h0001_2345, 32'h0000_0010, 2'b00, 32'h0012_3450, 32, 1'b0, -1);
        run_op("half",      32'hFFFF_0003, 32'h0002_0004, 2'b01, 32'hFFFE_000C, 16, 1'b0, -1);
        run_op("byte_b2b",  32'h10FF_0203, 32'h1002_0304, 2'b10, 32'h00FE_060C,  8, 1'b1, -1);
        run_op("word_max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001, 32, 1'b0, -1);
        run_op("word_ign",  32'h0000_0007, 32'h0000_0006, 2'b00, 32'h0000_002A, 32, 1'b0,  5);
        run_op("half_b2b",  32'h8000_1234, 32'h0002_0010, 2'b01, 32'h0000_2340, 16, 1'b1, -1);
        run_op("rsvd",      32'h1234_5678, 32'h9ABC_DEF0, 2'b11, 32'h0000_0000,  0, 1'b0, -1);
        run_op("byte_max",  32'hFFFF_FFFF, 32'h01FF_0280, 2'b10, 32'hFF01_FE80,  8, 1'b0, -1);

        // Reset in the middle of a half-mode operation.
        @(negedge clk);
        A         = 32'h0003_0005;
        B         = 32'h0007_0009;
        pack_mode = 2'b01;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("midrun_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_done", 32'(done), 32'd0);
        check("midrun_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midrun_no_done_pulse", 32'(done_cnt), 32'd0);
        check("midrun_result_held", result, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
